// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared widths, ROM word layout and FSM encoding for the song reader
package song_pkg;

    localparam int ADDR_W   = 7;
    localparam int SONG_W   = 2;
    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int IDX_W    = ADDR_W - SONG_W;
    localparam int WORD_W   = NOTE_W + DUR_W;
    localparam int NOTE_LSB = DUR_W;
    localparam int DUR_LSB  = 0;

    localparam logic [IDX_W-1:0]  LAST_IDX  = '1;
    localparam logic [DUR_W-1:0]  END_DUR   = '0;
    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_DONE
    } state_e;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[NOTE_LSB +: NOTE_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_LSB +: DUR_W];
    endfunction

endpackage

// File: rtl/song_note_timer.sv
// rtl/song_note_timer.sv - counts accepted beats of the current note and flags its final beat
module song_note_timer
    import song_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [DUR_W-1:0] duration_i,
    output logic             last_beat_o
);

    logic [DUR_W-1:0] count_q;
    logic [DUR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + DUR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Duration is never 0 here: end markers are diverted to DONE before PLAY.
    assign last_beat_o = enable_i && (count_q == duration_i - DUR_W'(1));

endmodule

// File: rtl/song_reader.sv
// rtl/song_reader.sv - walks one song's ROM region and presents timed notes to the note player
module song_reader
    import song_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              play_i,
    input  logic [SONG_W-1:0] song_i,
    input  logic              beat_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [WORD_W-1:0] rom_dout_i,
    output logic [NOTE_W-1:0] note_o,
    output logic [DUR_W-1:0]  duration_o,
    output logic              new_note_o,
    output logic              playing_o,
    output logic              song_done_o
);

    state_e            state_q, state_d;
    logic              play_q;
    logic [SONG_W-1:0] song_q, song_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              new_note_q, new_note_d;

    logic              timer_clear;
    logic              timer_enable;
    logic              last_beat;
    logic              song_switch;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;

    assign rom_note     = word_note(rom_dout_i);
    assign rom_dur      = word_dur(rom_dout_i);
    assign song_switch  = play_i && (song_i != song_q);
    assign timer_enable = (state_q == ST_PLAY) && play_i && beat_i;

    song_note_timer u_timer (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (timer_clear),
        .enable_i    (timer_enable),
        .duration_i  (dur_q),
        .last_beat_o (last_beat)
    );

    always_comb begin
        state_d     = state_q;
        song_d      = song_q;
        index_d     = index_q;
        note_d      = note_q;
        dur_d       = dur_q;
        new_note_d  = 1'b0;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (play_i && !play_q) begin
                    song_d  = song_i;
                    index_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH, ST_LOAD, ST_PLAY: begin
                // A new song selection outranks loading and advancing alike.
                if (song_switch) begin
                    song_d  = song_i;
                    index_d = '0;
                    state_d = ST_FETCH;
                end else if (state_q == ST_FETCH) begin
                    state_d = ST_LOAD;
                end else if (state_q == ST_LOAD) begin
                    if (rom_dur == END_DUR) begin
                        note_d  = REST_NOTE;
                        state_d = ST_DONE;
                    end else begin
                        note_d      = rom_note;
                        dur_d       = rom_dur;
                        timer_clear = 1'b1;
                        new_note_d  = 1'b1;
                        state_d     = ST_PLAY;
                    end
                end else if (last_beat) begin
                    if (index_q == LAST_IDX) begin
                        note_d  = REST_NOTE;
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                index_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            play_q     <= 1'b0;
            song_q     <= '0;
            index_q    <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            new_note_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            play_q     <= play_i;
            song_q     <= song_d;
            index_q    <= index_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            new_note_q <= new_note_d;
        end
    end

    assign rom_addr_o  = {song_q, index_q};
    assign note_o      = note_q;
    assign duration_o  = dur_q;
    assign new_note_o  = new_note_q;
    assign playing_o   = (state_q == ST_PLAY) && play_i;
    assign song_done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - randomized self-checking bench for song_reader with a behavioural song ROM
module tb_song_reader;

    logic        clk_i;
    logic        reset_n_i;
    logic        play_i;
    logic [1:0]  song_i;
    logic        beat_i;
    logic [6:0]  rom_addr_o;
    logic [11:0] rom_dout_i;
    logic [5:0]  note_o;
    logic [5:0]  duration_o;
    logic        new_note_o;
    logic        playing_o;
    logic        song_done_o;

    logic [11:0] rom [0:127];
    int n_checks;
    int n_errors;

    song_reader dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .play_i      (play_i),
        .song_i      (song_i),
        .beat_i      (beat_i),
        .rom_addr_o  (rom_addr_o),
        .rom_dout_i  (rom_dout_i),
        .note_o      (note_o),
        .duration_o  (duration_o),
        .new_note_o  (new_note_o),
        .playing_o   (playing_o),
        .song_done_o (song_done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) rom_dout_i <= rom[rom_addr_o];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0;
        play_i    = 1'b0;
        beat_i    = 1'b0;
        step();
        step();
        reset_n_i = 1'b1;
        step();
    endtask

    task automatic init_rom();
        int m2;
        int m3;
        for (int i = 0; i < 128; i++) begin
            rom[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 5))};
        end
        rom[0]  = {6'd49, 6'd12};
        rom[1]  = {6'd1, 6'd8};
        rom[28] = {6'd5, 6'd0};
        rom[63] = {6'd42, 6'd9};
        rom[64] = {6'd43, 6'd6};
        m2 = $urandom_range(3, 31);
        rom[64 + m2][5:0] = 6'd0;
        m3 = $urandom_range(2, 32);
        if (m3 < 32) rom[96 + m3][5:0] = 6'd0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        play_i    = 1'b0;
        song_i    = 2'd0;
        beat_i    = 1'b0;
        step();
        n_checks++;
        if ({rom_addr_o, note_o, duration_o, new_note_o, playing_o, song_done_o} !== 22'd0) begin
            n_errors++;
            $display("FAIL reset_outputs got addr=%0d note=%0d dur=%0d flags=%b expected all 0",
                     rom_addr_o, note_o, duration_o, {new_note_o, playing_o, song_done_o});
        end
        reset_n_i = 1'b1;
        step();
    endtask

    // First note latency/contents, then a pause of 20 beats partway through it.
    task automatic test_pause();
        song_i = 2'd0;
        play_i = 1'b1;
        step();
        n_checks++;
        if ({rom_addr_o, new_note_o} !== {7'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL first_fetch got addr=%0d nn=%b expected addr=0 nn=0", rom_addr_o, new_note_o);
        end
        step();
        step();
        n_checks++;
        if ({new_note_o, playing_o, note_o, duration_o} !== {2'b11, 6'd49, 6'd12}) begin
            n_errors++;
            $display("FAIL first_note got nn=%b pl=%b note=%0d dur=%0d expected 1 1 49 12",
                     new_note_o, playing_o, note_o, duration_o);
        end
        for (int k = 0; k < 5; k++) begin
            beat_i = 1'b1;
            step();
            beat_i = 1'b0;
            step();
        end
        play_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            beat_i = 1'b1;
            step();
            beat_i = 1'b0;
            n_checks++;
            if ({playing_o, new_note_o, rom_addr_o, note_o, duration_o} !== {2'b00, 7'd0, 6'd49, 6'd12}) begin
                n_errors++;
                $display("FAIL paused beat %0d got pl=%b nn=%b addr=%0d note=%0d dur=%0d expected 0 0 0 49 12",
                         k, playing_o, new_note_o, rom_addr_o, note_o, duration_o);
            end
        end
        play_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            beat_i = 1'b1;
            step();
            beat_i = 1'b0;
            n_checks++;
            if ({playing_o, rom_addr_o} !== {1'b1, 7'd0}) begin
                n_errors++;
                $display("FAIL resumed beat %0d got pl=%b addr=%0d expected 1 0", k, playing_o, rom_addr_o);
            end
        end
        beat_i = 1'b1;
        step();
        beat_i = 1'b0;
        n_checks++;
        if ({rom_addr_o, playing_o} !== {7'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL advance got addr=%0d pl=%b expected addr=1 pl=0", rom_addr_o, playing_o);
        end
        step();
        n_checks++;
        if ({note_o, duration_o} !== {6'd49, 6'd12}) begin
            n_errors++;
            $display("FAIL gap_hold got note=%0d dur=%0d expected 49 12", note_o, duration_o);
        end
        step();
        n_checks++;
        if ({new_note_o, note_o, duration_o} !== {1'b1, 6'd1, 6'd8}) begin
            n_errors++;
            $display("FAIL second_note got nn=%b note=%0d dur=%0d expected 1 1 8", new_note_o, note_o, duration_o);
        end
        apply_reset();
    endtask

    // Song change lands on the same cycle as the note's final beat.
    task automatic test_switch();
        song_i = 2'd0;
        play_i = 1'b1;
        step();
        step();
        step();
        for (int k = 0; k < 11; k++) begin
            beat_i = 1'b1;
            step();
        end
        song_i = 2'd2;
        step();
        beat_i = 1'b0;
        n_checks++;
        if ({rom_addr_o, new_note_o, playing_o} !== {7'd64, 2'b00}) begin
            n_errors++;
            $display("FAIL switch_fetch got addr=%0d nn=%b pl=%b expected 64 0 0", rom_addr_o, new_note_o, playing_o);
        end
        step();
        step();
        n_checks++;
        if ({new_note_o, note_o, duration_o} !== {1'b1, 6'd43, 6'd6}) begin
            n_errors++;
            $display("FAIL switch_note got nn=%b note=%0d dur=%0d expected 1 43 6", new_note_o, note_o, duration_o);
        end
        apply_reset();
    endtask

    // Reference: the song is the run of entries before the first zero duration, capped at 32.
    task automatic play_song(input int s);
        int         addr_q[$];
        bit         marker;
        logic [5:0] prev_note;
        int         base;
        int         a;
        int         dur;
        int         beats;
        base      = s * 32;
        marker    = 1'b0;
        prev_note = 6'd0;
        addr_q    = {};
        for (int i = 0; i < 32; i++) begin
            if (rom[base + i][5:0] == 6'd0) begin
                marker = 1'b1;
                break;
            end
            addr_q.push_back(base + i);
        end
        song_i = s[1:0];
        play_i = 1'b1;
        step();
        foreach (addr_q[k]) begin
            a = addr_q[k];
            n_checks++;
            if ({rom_addr_o, new_note_o} !== {a[6:0], 1'b0}) begin
                n_errors++;
                $display("FAIL song%0d fetch got addr=%0d nn=%b expected addr=%0d nn=0", s, rom_addr_o, new_note_o, a);
            end
            step();
            n_checks++;
            if ({note_o, new_note_o} !== {prev_note, 1'b0}) begin
                n_errors++;
                $display("FAIL song%0d hold got note=%0d nn=%b expected note=%0d nn=0", s, note_o, new_note_o, prev_note);
            end
            step();
            n_checks++;
            if ({new_note_o, playing_o, note_o, duration_o} !== {2'b11, rom[a]}) begin
                n_errors++;
                $display("FAIL song%0d new_note addr=%0d got nn=%b pl=%b note=%0d dur=%0d expected 1 1 %0d %0d",
                         s, a, new_note_o, playing_o, note_o, duration_o, rom[a][11:6], rom[a][5:0]);
            end
            dur   = int'(rom[a][5:0]);
            beats = 0;
            for (int c = 0; c < 400 && beats < dur; c++) begin
                beat_i = ($urandom_range(0, 2) != 0);
                if (beat_i) beats++;
                step();
                beat_i = 1'b0;
                if (beats < dur) begin
                    n_checks++;
                    if ({new_note_o, playing_o, rom_addr_o} !== {2'b01, a[6:0]}) begin
                        n_errors++;
                        $display("FAIL song%0d playing addr=%0d beat=%0d got nn=%b pl=%b addr=%0d",
                                 s, a, beats, new_note_o, playing_o, rom_addr_o);
                    end
                end
            end
            prev_note = rom[a][11:6];
        end
        if (marker) begin
            a = base + addr_q.size();
            n_checks++;
            if ({rom_addr_o, new_note_o} !== {a[6:0], 1'b0}) begin
                n_errors++;
                $display("FAIL song%0d marker_fetch got addr=%0d expected %0d", s, rom_addr_o, a);
            end
            step();
            step();
        end
        n_checks++;
        if ({song_done_o, playing_o, new_note_o, note_o} !== {3'b100, 6'd0}) begin
            n_errors++;
            $display("FAIL song%0d done got sd=%b pl=%b nn=%b note=%0d expected 1 0 0 0",
                     s, song_done_o, playing_o, new_note_o, note_o);
        end
        n_checks++;
        if (rom_addr_o[6:5] !== s[1:0]) begin
            n_errors++;
            $display("FAIL song%0d region got addr=%0d", s, rom_addr_o);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if ({song_done_o, new_note_o, playing_o, rom_addr_o} !== {3'b000, s[1:0], 5'd0}) begin
                n_errors++;
                $display("FAIL song%0d no_restart cyc=%0d got sd=%b nn=%b pl=%b addr=%0d expected 0 0 0 %0d",
                         s, c, song_done_o, new_note_o, playing_o, rom_addr_o, base);
            end
        end
        play_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_play();
        song_i = 2'd3;
        play_i = 1'b1;
        step();
        step();
        step();
        beat_i = 1'b1;
        step();
        beat_i = 1'b0;
        reset_n_i = 1'b0;
        play_i    = 1'b0;
        #2;
        n_checks++;
        if ({rom_addr_o, note_o, duration_o, new_note_o, playing_o, song_done_o} !== 22'd0) begin
            n_errors++;
            $display("FAIL async_reset got addr=%0d note=%0d dur=%0d flags=%b expected all 0",
                     rom_addr_o, note_o, duration_o, {new_note_o, playing_o, song_done_o});
        end
        step();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if ({rom_addr_o, new_note_o, playing_o, song_done_o} !== 10'd0) begin
                n_errors++;
                $display("FAIL post_reset_idle cyc=%0d got addr=%0d flags=%b expected 0", c, rom_addr_o,
                         {new_note_o, playing_o, song_done_o});
            end
        end
        song_i = 2'd1;
        play_i = 1'b1;
        step();
        n_checks++;
        if (rom_addr_o !== 7'd32) begin
            n_errors++;
            $display("FAIL post_reset_start got addr=%0d expected 32", rom_addr_o);
        end
        step();
        step();
        n_checks++;
        if ({new_note_o, note_o, duration_o} !== {1'b1, rom[32]}) begin
            n_errors++;
            $display("FAIL post_reset_note got nn=%b note=%0d dur=%0d expected 1 %0d %0d",
                     new_note_o, note_o, duration_o, rom[32][11:6], rom[32][5:0]);
        end
        apply_reset();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n_i = 1'b0;
        play_i    = 1'b0;
        song_i    = 2'd0;
        beat_i    = 1'b0;
        init_rom();
        test_reset();
        test_pause();
        test_switch();
        play_song(0);
        play_song(1);
        play_song(2);
        play_song(3);
        play_song(0);
        test_reset_mid_play();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
